nrs_seq_ctrl_banked: RTL
========================

Name: nrs_seq_ctrl_banked

Overview:
- Parametrised control FSM for the NRS Gold-sequence generator (x1/x2 LFSR pair plus output XOR).
- Per frame it sequences RUNS_PER_FRAME runs; each run is: seed LFSRs from a fresh cinit, fast-forward NC shifts, emit OUT_PER_RUN bits into a ping-pong output buffer.
- Relative to the single-run controller it adds: internal run counting, cinit prefetch, multi-step fast shifting, two-bank buffer backpressure, and abort.

Parameters:
- NC, 1600: Gold-sequence discard length (shifts before the first output bit).
- SHIFTS_PER_CLK, 31: LFSR steps per cycle in fast-shift mode. Localparam SHIFT_CYCLES = ceil(NC/SHIFTS_PER_CLK), giving 52 at defaults.
- OUT_PER_RUN, 4: output bits written per run.
- RUNS_PER_FRAME, 20: runs (cinit values) per frame.
- ADDR_W, max(1, clog2(OUT_PER_RUN)): width of the write address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  new-frame pulse; honoured only in IDLE.
- abort  in  1  synchronous abort; all states go to IDLE.
- cinit_req  out  1  one-cycle pulse requesting the cinit generator to compute the next cinit.
- cinit_valid  in  1  one-cycle pulse: the requested cinit is ready.
- init  out  1  load LFSRs from cinit.
- shift_fast  out  1  step LFSRs by SHIFTS_PER_CLK.
- shift_x  out  1  step LFSRs by 1.
- out_en  out  1  output bit valid.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  offset within the bank.
- wr_bank  out  1  target bank.
- bank_release  in  2  per-bank pulse from the consumer; frees that bank.
- run_idx  out  clog2(RUNS_PER_FRAME)  current run.
- busy  out  1  asserted when cs != IDLE.
- frame_done  out  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset values: cs=IDLE; all outputs 0; bank_full=2'b00; req_out=0; pending=0; counters 0.
- Outputs init, shift_fast, shift_x, out_en, wr_en are decoded combinationally from cs. cinit_req and frame_done are registered pulses.
- IDLE:
  - If start, go to WAIT_CINIT; clear run_idx and wr_bank; pulse cinit_req in the first WAIT_CINIT cycle; set req_out.
- WAIT_CINIT:
  - If pending or (req_out & cinit_valid), go to WAIT_BANK.
- WAIT_BANK:
  - Always occupies at least 1 cycle.
  - If !bank_full[wr_bank], go to SEED; otherwise stay (backpressure).
- SEED: 1 cycle.
  - init=1.
  - Clear pending and wr_addr.
  - Go to SHIFT.
- SHIFT: exactly SHIFT_CYCLES cycles.
  - shift_fast=1.
  - In the first SHIFT cycle, if run_idx < RUNS_PER_FRAME-1, pulse cinit_req (prefetch) and set req_out.
  - Go to EVAL.
- EVAL: exactly OUT_PER_RUN cycles.
  - shift_x=1, out_en=1, wr_en=1.
  - wr_addr increments each cycle (0..OUT_PER_RUN-1).
  - On the last EVAL cycle: set bank_full[wr_bank]; toggle wr_bank.
  - If run_idx == RUNS_PER_FRAME-1: go to IDLE and pulse frame_done.
  - Otherwise: increment run_idx and go to WAIT_CINIT.
- Prefetch bookkeeping:
  - A cinit_valid seen while req_out=1 and cs is not WAIT_CINIT sets pending and clears req_out.
  - cinit_valid with req_out=0 is ignored.
- NC and shifting: NC is not required to be a multiple of SHIFTS_PER_CLK. The datapath masks the final fast step; the controller only counts cycles.
- bank_release[b] clears bank_full[b]. If a set and a release hit the same bank in the same cycle, set wins.
- abort has priority over every transition, including start in the same cycle. Next cycle is IDLE, with run_idx, wr_addr, wr_bank, pending, req_out and bank_full all cleared. No frame_done pulse.
- start outside IDLE is ignored.
- Asynchronous reset mid-run returns everything to reset values immediately.
- Counters: shift counter width clog2(SHIFT_CYCLES+1), cleared outside SHIFT. The EVAL counter reuses wr_addr.

Test Plan:
1. Defaults, both banks free, cinit_valid 3 cycles after each req, start at cycle 0:
   - cinit_req at cycle 1, SEED at cycle 6, shift_fast during cycles 7-58, wr_en during cycles 59-62 with wr_addr 0,1,2,3 and wr_bank=0.
   - Prefetch req at cycle 7.
2. RUNS_PER_FRAME=3, consumer releases each bank 2 cycles after it fills:
   - Exactly 12 writes; wr_bank sequence 0,1,0.
   - run_idx steps 0,1,2.
   - frame_done pulses once, then IDLE, busy=0.
   - No prefetch req during run 2.
3. Consumer never releases:
   - Run 0 fills bank 0, run 1 fills bank 1, run 2 holds in WAIT_BANK indefinitely.
   - Releasing bank 0 causes SEED 2 cycles later.
4. cinit_valid delayed to 70 cycles after the prefetch req:
   - FSM waits in WAIT_CINIT after EVAL and proceeds 2 cycles after valid (via WAIT_BANK) with no extra req.
   - Spurious cinit_valid while req_out=0 has no effect.
5. abort and start asserted together mid-SHIFT of run 1:
   - IDLE next cycle, bank_full=00, no frame_done.
   - A later start begins at run 0, bank 0.
6. NC=100, SHIFTS_PER_CLK=31, OUT_PER_RUN=6:
   - shift_fast for 4 cycles, then 6 writes with wr_addr 0..5.

Source files
------------

// File: rtl/nrs_seq_ctrl_banked_if.sv
// Control/handshake bundle between the banked NRS sequence controller, its cinit
// generator, the x1/x2 LFSR datapath and the two-bank output buffer.
interface nrs_seq_ctrl_banked_if #(
    parameter int ADDR_W = 2,
    parameter int RUN_W  = 5
);
    logic              start;
    logic              abort;
    logic              cinit_req;
    logic              cinit_valid;
    logic              init;
    logic              shift_fast;
    logic              shift_x;
    logic              out_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;
    logic [1:0]        bank_release;
    logic [RUN_W-1:0]  run_idx;
    logic              busy;
    logic              frame_done;

    // Controller side
    modport master (
        input  start, abort, cinit_valid, bank_release,
        output cinit_req, init, shift_fast, shift_x, out_en, wr_en,
               wr_addr, wr_bank, run_idx, busy, frame_done
    );

    // Environment side (cinit generator, datapath, consumer)
    modport slave (
        output start, abort, cinit_valid, bank_release,
        input  cinit_req, init, shift_fast, shift_x, out_en, wr_en,
               wr_addr, wr_bank, run_idx, busy, frame_done
    );
endinterface

// File: rtl/nrs_seq_ctrl_banked.sv
// Frame-level control FSM for the NRS Gold-sequence generator: per run it seeds the
// LFSRs, fast-forwards NC shifts and writes OUT_PER_RUN bits into a ping-pong buffer.
module nrs_seq_ctrl_banked #(
    parameter int NC             = 1600,
    parameter int SHIFTS_PER_CLK = 31,
    parameter int OUT_PER_RUN    = 4,
    parameter int RUNS_PER_FRAME = 20,
    parameter int ADDR_W         = (OUT_PER_RUN > 1) ? $clog2(OUT_PER_RUN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    nrs_seq_ctrl_banked_if.master bus_io
);
    localparam int SHIFT_CYCLES = (NC + SHIFTS_PER_CLK - 1) / SHIFTS_PER_CLK;
    localparam int SCNT_W       = $clog2(SHIFT_CYCLES + 1);
    localparam int RUN_W        = (RUNS_PER_FRAME > 1) ? $clog2(RUNS_PER_FRAME) : 1;

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SHIFT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OUT_PER_RUN - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUNS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_CINIT = 3'd1,
        ST_WAIT_BANK  = 3'd2,
        ST_SEED       = 3'd3,
        ST_SHIFT      = 3'd4,
        ST_EVAL       = 3'd5
    } state_e;

    state_e            cs_q, cs_d;
    logic [RUN_W-1:0]  run_idx_q, run_idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              req_out_q, req_out_d;
    logic              pending_q, pending_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              cinit_req_q, cinit_req_d;
    logic              frame_done_q, frame_done_d;

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q         <= ST_IDLE;
            run_idx_q    <= {RUN_W{1'b0}};
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            req_out_q    <= 1'b0;
            pending_q    <= 1'b0;
            scnt_q       <= {SCNT_W{1'b0}};
            cinit_req_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cs_q         <= cs_d;
            run_idx_q    <= run_idx_d;
            wr_addr_q    <= wr_addr_d;
            wr_bank_q    <= wr_bank_d;
            bank_full_q  <= bank_full_d;
            req_out_q    <= req_out_d;
            pending_q    <= pending_d;
            scnt_q       <= scnt_d;
            cinit_req_q  <= cinit_req_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, counters and prefetch bookkeeping; abort overrides everything
    always_comb begin
        cs_d         = cs_q;
        run_idx_d    = run_idx_q;
        wr_addr_d    = wr_addr_q;
        wr_bank_d    = wr_bank_q;
        bank_full_d  = bank_full_q & ~bus_io.bank_release;
        req_out_d    = req_out_q;
        pending_d    = pending_q;
        scnt_d       = {SCNT_W{1'b0}};
        cinit_req_d  = 1'b0;
        frame_done_d = 1'b0;

        if (bus_io.abort) begin
            cs_d        = ST_IDLE;
            run_idx_d   = {RUN_W{1'b0}};
            wr_addr_d   = {ADDR_W{1'b0}};
            wr_bank_d   = 1'b0;
            bank_full_d = 2'b00;
            req_out_d   = 1'b0;
            pending_d   = 1'b0;
        end else begin
            // A prefetched cinit that lands before we need it is parked in pending
            if (bus_io.cinit_valid && req_out_q && (cs_q != ST_WAIT_CINIT)) begin
                pending_d = 1'b1;
                req_out_d = 1'b0;
            end else begin
                pending_d = pending_q;
                req_out_d = req_out_q;
            end

            case (cs_q)
                ST_IDLE: begin
                    if (bus_io.start) begin
                        cs_d        = ST_WAIT_CINIT;
                        run_idx_d   = {RUN_W{1'b0}};
                        wr_bank_d   = 1'b0;
                        cinit_req_d = 1'b1;
                        req_out_d   = 1'b1;
                    end else begin
                        cs_d = ST_IDLE;
                    end
                end
                ST_WAIT_CINIT: begin
                    if (pending_q || (req_out_q && bus_io.cinit_valid)) begin
                        cs_d      = ST_WAIT_BANK;
                        req_out_d = 1'b0;
                    end else begin
                        cs_d = ST_WAIT_CINIT;
                    end
                end
                ST_WAIT_BANK: begin
                    if (!bank_full_q[wr_bank_q]) begin
                        cs_d = ST_SEED;
                    end else begin
                        cs_d = ST_WAIT_BANK;
                    end
                end
                ST_SEED: begin
                    cs_d      = ST_SHIFT;
                    pending_d = 1'b0;
                    wr_addr_d = {ADDR_W{1'b0}};
                    if (run_idx_q < RUN_LAST) begin
                        cinit_req_d = 1'b1;
                        req_out_d   = 1'b1;
                    end else begin
                        cinit_req_d = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (scnt_q == SCNT_LAST) begin
                        cs_d = ST_EVAL;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (wr_addr_q == ADDR_LAST) begin
                        wr_addr_d              = {ADDR_W{1'b0}};
                        bank_full_d[wr_bank_q] = 1'b1;
                        wr_bank_d              = ~wr_bank_q;
                        if (run_idx_q == RUN_LAST) begin
                            cs_d         = ST_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            cs_d      = ST_WAIT_CINIT;
                            run_idx_d = run_idx_q + RUN_W'(1);
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    cs_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus_io.init       = (cs_q == ST_SEED);
    assign bus_io.shift_fast = (cs_q == ST_SHIFT);
    assign bus_io.shift_x    = (cs_q == ST_EVAL);
    assign bus_io.out_en     = (cs_q == ST_EVAL);
    assign bus_io.wr_en      = (cs_q == ST_EVAL);
    assign bus_io.busy       = (cs_q != ST_IDLE);
    assign bus_io.wr_addr    = wr_addr_q;
    assign bus_io.wr_bank    = wr_bank_q;
    assign bus_io.run_idx    = run_idx_q;
    assign bus_io.cinit_req  = cinit_req_q;
    assign bus_io.frame_done = frame_done_q;
endmodule
